// File: rtl/prog_timer_pkg.sv
// Shared constants and state encoding for prog_timer.
package prog_timer_pkg;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   localparam logic MODE_PERIODIC = 1'b0;
   localparam logic MODE_ONESHOT  = 1'b1;

   localparam int DEF_WIDTH       = 32;
   localparam int DEF_PERIOD      = 3;
   localparam int DEF_PRESC_WIDTH = 8;

endpackage

// File: rtl/prog_timer_prescaler.sv
// Divides enabled cycles by (presc_value+1); tick fires on the last enabled cycle of each group.
module prog_timer_prescaler #(
   parameter int PRESC_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   async_nreset,
   input  logic                   clear,
   input  logic                   enable,
   input  logic [PRESC_WIDTH-1:0] presc_value,
   output logic                   tick
);

   logic [PRESC_WIDTH-1:0] presc_cnt;
   logic                   at_term;

   assign at_term = (presc_cnt == presc_value);
   assign tick    = enable && at_term;

   always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) begin
         presc_cnt <= '0;
      end else if (clear) begin
         presc_cnt <= '0;
      end else if (enable) begin
         presc_cnt <= at_term ? '0 : presc_cnt + PRESC_WIDTH'(1);
      end
   end

endmodule

// File: rtl/prog_timer.sv
// Programmable periodic / one-shot timer with Mealy trigger pulse.
// Optional prescaler on the count tick: define PROG_TIMER_PRESCALER_EN.
module prog_timer
   import prog_timer_pkg::*;
#(
   parameter int WIDTH          = DEF_WIDTH,
   parameter int DEFAULT_PERIOD = DEF_PERIOD,
   parameter int PRESC_WIDTH    = DEF_PRESC_WIDTH
) (
   input  logic                   clk,
   input  logic                   async_nreset,
   input  logic                   clear,
   input  logic                   enable,
   input  logic                   load,
   input  logic [WIDTH-1:0]       load_value,
   input  logic                   mode,
`ifdef PROG_TIMER_PRESCALER_EN
   input  logic [PRESC_WIDTH-1:0] presc_value,
`endif
   output logic                   trigger,
   output logic [WIDTH-1:0]       count,
   output logic                   busy
);

   if (WIDTH < 31 && (DEFAULT_PERIOD < 0 || DEFAULT_PERIOD >= (1 << WIDTH))) begin : g_bad_period
      $error("prog_timer: DEFAULT_PERIOD does not fit in WIDTH bits");
   end
   if (PRESC_WIDTH < 1) begin : g_bad_presc
      $error("prog_timer: PRESC_WIDTH must be at least 1");
   end

   state_t           state, state_nxt;
   logic [WIDTH-1:0] counter_reg, counter_nxt;
   logic [WIDTH-1:0] period_reg, period_nxt;
   logic             tick;

`ifdef PROG_TIMER_PRESCALER_EN
   prog_timer_prescaler #(
      .PRESC_WIDTH (PRESC_WIDTH)
   ) u_presc (
      .clk          (clk),
      .async_nreset (async_nreset),
      .clear        (clear | load),
      .enable       (enable),
      .presc_value  (presc_value),
      .tick         (tick)
   );
`else
   assign tick = enable;
`endif

   always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) begin
         state       <= ST_RUN;
         counter_reg <= '0;
         period_reg  <= WIDTH'(DEFAULT_PERIOD);
      end else begin
         state       <= state_nxt;
         counter_reg <= counter_nxt;
         period_reg  <= period_nxt;
      end
   end

   // load outranks clear, which outranks the tick; both suppress the pulse.
   always_comb begin
      state_nxt   = state;
      counter_nxt = counter_reg;
      period_nxt  = period_reg;
      trigger     = 1'b0;
      if (load) begin
         period_nxt  = load_value;
         counter_nxt = '0;
         state_nxt   = ST_RUN;
      end else if (clear) begin
         counter_nxt = '0;
         state_nxt   = ST_RUN;
      end else begin
         case (state)
            ST_RUN: begin
               if (tick) begin
                  if (counter_reg == period_reg) begin
                     trigger     = 1'b1;
                     counter_nxt = '0;
                     if (mode == MODE_ONESHOT) state_nxt = ST_HALT;
                  end else begin
                     counter_nxt = counter_reg + WIDTH'(1);
                  end
               end
            end
            ST_HALT: counter_nxt = '0;
            default: state_nxt = ST_RUN;
         endcase
      end
   end

   assign count = counter_reg;
   assign busy  = (state == ST_RUN);

endmodule

// File: tb/tb_prog_timer.sv
// Directed, table-driven bench for prog_timer plus a WIDTH=4 instance for wrap checks.
module tb_prog_timer;

   logic        clk = 1'b0;
   logic        async_nreset = 1'b0;
   logic        clear = 1'b0, enable = 1'b0, load = 1'b0, mode = 1'b0;
   logic [31:0] load_value = '0;
   logic        trigger, busy;
   logic [31:0] count;

   logic        clear4 = 1'b0, enable4 = 1'b0, load4 = 1'b0;
   logic [3:0]  load_value4 = '0;
   logic        trigger4, busy4;
   logic [3:0]  count4;

`ifdef PROG_TIMER_PRESCALER_EN
   logic [7:0]  presc_value = '0;
   logic [7:0]  presc_value4 = '0;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   prog_timer #(.WIDTH(32), .DEFAULT_PERIOD(3), .PRESC_WIDTH(8)) dut (
      .clk          (clk),
      .async_nreset (async_nreset),
      .clear        (clear),
      .enable       (enable),
      .load         (load),
      .load_value   (load_value),
      .mode         (mode),
`ifdef PROG_TIMER_PRESCALER_EN
      .presc_value  (presc_value),
`endif
      .trigger      (trigger),
      .count        (count),
      .busy         (busy)
   );

   prog_timer #(.WIDTH(4), .DEFAULT_PERIOD(3), .PRESC_WIDTH(8)) dut4 (
      .clk          (clk),
      .async_nreset (async_nreset),
      .clear        (clear4),
      .enable       (enable4),
      .load         (load4),
      .load_value   (load_value4),
      .mode         (1'b0),
`ifdef PROG_TIMER_PRESCALER_EN
      .presc_value  (presc_value4),
`endif
      .trigger      (trigger4),
      .count        (count4),
      .busy         (busy4)
   );

   typedef struct {
      logic        ld;
      logic [31:0] lv;
      logic        clr;
      logic        en;
      logic        md;
      logic        etrig;
      logic [31:0] ecnt;
      logic        ebusy;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic v(input logic ld, input logic [31:0] lv, input logic clr, input logic en,
                    input logic md, input logic et, input logic [31:0] ec, input logic eb);
      vecs.push_back('{ld, lv, clr, en, md, et, ec, eb});
   endtask

   // Inputs change at negedge; outputs checked 1 unit later, well before the rising edge.
   task automatic drive(input logic ld, input logic [31:0] lv, input logic clr,
                        input logic en, input logic md);
      load = ld; load_value = lv; clear = clr; enable = en; mode = md;
      #1;
   endtask

   task automatic finish_cycle;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      // A: default period 3, periodic
      for (int k = 1; k <= 12; k++) v(0, 0, 0, 1, 0, (k % 4) == 0, (k - 1) % 4, 1);
      // B: load 5, enable gap holds the count
      v(1, 5, 0, 1, 0, 0, 0, 1);
      v(0, 0, 0, 1, 0, 0, 0, 1);
      v(0, 0, 0, 1, 0, 0, 1, 1);
      v(0, 0, 0, 1, 0, 0, 2, 1);
      v(0, 0, 0, 0, 0, 0, 3, 1);
      v(0, 0, 0, 1, 0, 0, 3, 1);
      v(0, 0, 0, 1, 0, 0, 4, 1);
      v(0, 0, 0, 1, 0, 1, 5, 1);
      v(0, 0, 0, 1, 0, 0, 0, 1);
      // C: one-shot, period 2, then clear restarts
      v(1, 2, 0, 0, 1, 0, 1, 1);
      v(0, 0, 0, 1, 1, 0, 0, 1);
      v(0, 0, 0, 1, 1, 0, 1, 1);
      v(0, 0, 0, 1, 1, 1, 2, 1);
      v(0, 0, 0, 1, 1, 0, 0, 0);
      v(0, 0, 0, 1, 1, 0, 0, 0);
      v(0, 0, 0, 1, 1, 0, 0, 0);
      v(0, 0, 1, 1, 1, 0, 0, 0);
      v(0, 0, 0, 1, 1, 0, 0, 1);
      v(0, 0, 0, 1, 1, 0, 1, 1);
      v(0, 0, 0, 1, 1, 1, 2, 1);
      v(0, 0, 0, 1, 1, 0, 0, 0);
      // D: clear at terminal tick suppresses trigger; load+clear acts as load
      v(1, 2, 0, 0, 0, 0, 0, 0);
      v(0, 0, 0, 1, 0, 0, 0, 1);
      v(0, 0, 0, 1, 0, 0, 1, 1);
      v(0, 0, 1, 1, 0, 0, 2, 1);
      v(0, 0, 0, 0, 0, 0, 0, 1);
      v(1, 1, 1, 0, 0, 0, 0, 1);
      v(0, 0, 0, 1, 0, 0, 0, 1);
      v(0, 0, 0, 1, 0, 1, 1, 1);
      v(0, 0, 0, 1, 0, 0, 0, 1);
      v(0, 0, 0, 1, 0, 1, 1, 1);
      // E: period 0 periodic then one-shot
      v(1, 0, 0, 0, 0, 0, 0, 1);
      v(0, 0, 0, 1, 0, 1, 0, 1);
      v(0, 0, 0, 1, 0, 1, 0, 1);
      v(0, 0, 0, 1, 0, 1, 0, 1);
      v(0, 0, 0, 1, 1, 1, 0, 1);
      v(0, 0, 0, 1, 1, 0, 0, 0);
      v(0, 0, 0, 1, 1, 0, 0, 0);
      // F: mode switched mid-count applies at the next terminal tick
      v(1, 3, 0, 0, 0, 0, 0, 0);
      v(0, 0, 0, 1, 0, 0, 0, 1);
      v(0, 0, 0, 1, 0, 0, 1, 1);
      v(0, 0, 0, 1, 1, 0, 2, 1);
      v(0, 0, 0, 1, 1, 1, 3, 1);
      v(0, 0, 0, 1, 1, 0, 0, 0);

      // reset state
      #2;
      chk("rst_trig", {31'd0, trigger}, 32'd0);
      chk("rst_cnt", count, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_cnt4", {28'd0, count4}, 32'd0);
      @(negedge clk);
      async_nreset = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         drive(vecs[i].ld, vecs[i].lv, vecs[i].clr, vecs[i].en, vecs[i].md);
         chk($sformatf("v%0d_trig", i), {31'd0, trigger}, {31'd0, vecs[i].etrig});
         chk($sformatf("v%0d_cnt", i), count, vecs[i].ecnt);
         chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].ebusy});
         finish_cycle();
      end

      // WIDTH=4, period 15: count climbs to 15, trigger on 16th enabled cycle, wraps to 0
      drive(0, 0, 0, 0, 0);
      load4 = 1'b1; load_value4 = 4'd15; #1;
      finish_cycle();
      load4 = 1'b0; enable4 = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         #1;
         chk($sformatf("w4_cnt%0d", k), {28'd0, count4}, (k == 17) ? 32'd0 : 32'(k - 1));
         chk($sformatf("w4_trig%0d", k), {31'd0, trigger4}, {31'd0, k == 16});
         finish_cycle();
      end
      enable4 = 1'b0;

      // async reset mid-count discards a loaded period
      drive(1, 5, 0, 0, 0);
      finish_cycle();
      drive(0, 0, 0, 1, 0);
      finish_cycle();
      drive(0, 0, 0, 1, 0);
      finish_cycle();
      chk("pre_rst_cnt", count, 32'd2);
      #2 async_nreset = 1'b0;
      #1;
      chk("arst_cnt", count, 32'd0);
      chk("arst_trig", {31'd0, trigger}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      async_nreset = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         drive(0, 0, 0, 1, 0);
         chk($sformatf("post_rst_trig%0d", k), {31'd0, trigger}, {31'd0, k == 4});
         finish_cycle();
      end

`ifdef PROG_TIMER_PRESCALER_EN
      // prescaler 2, period 1: count steps every 3rd, trigger every 6th enabled cycle
      presc_value = 8'd2;
      drive(1, 1, 0, 0, 0);
      finish_cycle();
      for (int k = 1; k <= 12; k++) begin
         drive(0, 0, 0, 1, 0);
         chk($sformatf("presc_cnt%0d", k), count, 32'(((k - 1) / 3) % 2));
         chk($sformatf("presc_trig%0d", k), {31'd0, trigger}, {31'd0, (k % 6) == 0});
         finish_cycle();
      end
      presc_value = 8'd0;
`endif

      drive(0, 0, 0, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
